// File: rtl/booth_pkg.sv
// booth_pkg: shared widths and FSM state encoding for the sequential radix-4 Booth multiplier
package booth_pkg;
  localparam int OP_W = 16;
  localparam int PROD_W = 32;
  localparam int ITER = OP_W / 2;
  localparam int CNT_W = 3;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/booth2.sv
// booth2: radix-4 Booth encoder/selector producing a one's-complement partial product plus carry-in
module booth2
  import booth_pkg::*;
(
  input  logic [OP_W-1:0] y,
  input  logic            x2,
  input  logic            x1,
  input  logic            x0,
  output logic [OP_W:0]   y_pro,
  output logic            s,
  output logic            e
);
  logic one, two, neg;
  logic [OP_W:0] mag;
  always_comb begin
    one = x1 ^ x0;
    two = (x2 & ~x1 & ~x0) | (~x2 & x1 & x0);
    neg = x2 & ~(x1 & x0);
    mag = one ? {y[OP_W-1], y} : two ? {y, 1'b0} : '0;
    // negative selections are inverted here; s adds the +1 in the accumulator
    y_pro = neg ? ~mag : mag;
    s = neg;
    e = ~y_pro[OP_W];
  end
endmodule

// File: rtl/booth2_mul_seq.sv
// booth2_mul_seq: 16x16 signed multiplier iterating one shared booth2 selector over 8 cycles
module booth2_mul_seq
  import booth_pkg::*;
#(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] p
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [OP_W+1:0] acc_q, acc_d, sum, pp;
  logic [OP_W-1:0] q_q, q_d, bq_q, bq_d;
  logic qm1_q, qm1_d;
  logic [PROD_W-1:0] p_q, p_d;
  logic [OP_W:0] y_pro;
  logic s, e_unused, accept, zero;

  booth2 u_booth2 (
    .y    (bq_q),
    .x2   (q_q[1]),
    .x1   (q_q[0]),
    .x0   (qm1_q),
    .y_pro(y_pro),
    .s    (s),
    .e    (e_unused)
  );

  always_comb begin
    busy = state_q == ST_RUN;
    done = state_q == ST_DONE;
    accept = start & ~busy;
    zero = ZERO_SKIP && (a == '0 || b == '0);
    pp = {y_pro[OP_W], y_pro};
    sum = acc_q + pp + {{(OP_W+1){1'b0}}, s};
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    q_d = q_q;
    qm1_d = qm1_q;
    bq_d = bq_q;
    p_d = p_q;
    if (accept) begin
      acc_d = '0;
      q_d = a;
      qm1_d = 1'b0;
      bq_d = b;
      cnt_d = '0;
      state_d = zero ? ST_DONE : ST_RUN;
      p_d = zero ? '0 : p_q;
    end else if (busy) begin
      // low two bits of the sum retire into Q as the product's next LSBs
      acc_d = sum >>> 2;
      q_d = {sum[1:0], q_q[OP_W-1:2]};
      qm1_d = q_q[1];
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(ITER - 1)) begin
        state_d = ST_DONE;
        p_d = {acc_d[OP_W-1:0], q_d};
      end
    end else if (done) begin
      state_d = ST_IDLE;
    end
    p = p_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      q_q <= '0;
      qm1_q <= 1'b0;
      bq_q <= '0;
      p_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      q_q <= q_d;
      qm1_q <= qm1_d;
      bq_q <= bq_d;
      p_q <= p_d;
    end
  end
endmodule

// File: tb/tb_booth2_mul_seq.sv
// tb_booth2_mul_seq: scoreboard bench for booth2_mul_seq with directed and random operands
module tb_booth2_mul_seq;
  logic clk = 1'b0;
  logic rst, start;
  logic [15:0] a, b;
  logic busy, done, busy_nz, done_nz;
  logic [31:0] p, p_nz, exp_p;
  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  booth2_mul_seq #(.ZERO_SKIP(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .busy(busy), .done(done), .p(p)
  );
  booth2_mul_seq #(.ZERO_SKIP(1'b0)) u_nz (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .busy(busy_nz), .done(done_nz), .p(p_nz)
  );

  always @(negedge clk) begin
    if (done && busy) begin
      errors++;
      $display("FAIL overlap: done and busy both high");
    end
    if (done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: p=%h with no expected result", p);
      end else begin
        exp_p = sb.pop_front();
        if (p !== exp_p) begin
          errors++;
          $display("FAIL product: got %h expected %h", p, exp_p);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic [31:0] exp, input int lat);
    int n, bc;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    bc = int'(busy);
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
      bc += int'(busy);
    end
    chk("latency", n, lat);
    chk("busy_cycles", bc, (lat == 9) ? 8 : 0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [15:0] ra, rb;
    rst = 1'b1; start = 1'b1; a = 16'd5; b = 16'd5;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_p", p, 0);
    rst = 1'b0; start = 1'b0;

    issue(16'd3, 16'd5, 32'h0000000F, 9);
    issue(16'h8000, 16'h8000, 32'h40000000, 9);
    issue(16'h7FFF, 16'h8000, 32'hC0008000, 9);

    issue(16'd0, 16'd1234, 32'h0, 1);
    n = 1;
    chk("nz_busy", 32'(busy_nz), 1);
    while (!done_nz && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("nz_latency", n, 9);
    chk("nz_p", p_nz, 0);

    @(negedge clk);
    a = 16'd123; b = -16'sd45; start = 1'b1;
    sb.push_back(32'hFFFFEA61);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 16'd7; b = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("ignored_start_latency", n + 5, 9);
    repeat (12) @(negedge clk);

    @(negedge clk);
    a = 16'd1000; b = 16'd1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_p", p, 0);
    repeat (12) @(negedge clk);
    issue(16'hFFFF, 16'hFFFF, 32'h00000001, 9);

    @(negedge clk);
    a = -16'sd2; b = 16'd3; start = 1'b1;
    sb.push_back(32'hFFFFFFFA);
    sb.push_back(32'hFFFFD8F0);
    @(negedge clk);
    a = 16'd100; b = -16'sd100;
    n = 1;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_latency", n, 9);
    @(negedge clk);
    n = 1;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("b2b_second_latency", n, 9);
    repeat (12) @(negedge clk);

    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      issue(ra, rb, 32'(int'($signed(ra)) * int'($signed(rb))), (ra == 0 || rb == 0) ? 1 : 9);
    end

    repeat (12) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
